dec2_rr_arb: RTL
================

Name: dec2_rr_arb

Overview:
4-channel round-robin arbiter that sits directly upstream of the 2-to-4 decoder (dec2_dataflow / dec2_behavior). It selects one of four requesters and drives an encoded 2-bit grant index plus enable. These map straight onto the decoder's i_in / i_en inputs, so the decoder output is the one-hot grant vector. Each grant is held until the owner finishes, drops its request, or hits a hold timeout.

Parameters:
MAX_HOLD, 8, max cycles one grant may stay asserted (legal range 2..256); hold counter width = $clog2(MAX_HOLD).

Ports:
i_clk  input  1  clock; all state updates on rising edge
i_rst  input  1  reset; synchronous, active-high
i_req  input  4  request per channel; bit k = channel k
i_done  input  1  current owner finished; releases grant
o_idx  output  2  granted channel index; connects to decoder i_in
o_en  output  1  grant valid; connects to decoder i_en
o_timeout  output  1  one-cycle pulse when a grant is force-released by timeout

Behaviour:
- Reset (i_rst=1 at an edge): state=IDLE, o_en=0, o_idx=0, o_timeout=0, rr pointer ptr=0, hold counter=0. Reset takes priority over all other events, including mid-grant; o_en is 0 after that edge.
- FSM has two states: IDLE and GRANT.
- IDLE, i_req==0: remain in IDLE. o_en=0. o_idx keeps its last granted value.
- IDLE, i_req!=0:
  - Select the first set bit scanning ptr, ptr+1, ... mod 4.
  - At that edge: o_idx=selected, o_en=1, counter=0, go to GRANT.
  - Latency: request sampled at edge N gives o_en=1 after edge N.
- GRANT: o_en=1 and o_idx is stable. Counter increments by 1 each cycle the grant is not released.
- Release conditions, evaluated at each edge in GRANT:
  - (a) i_done=1
  - (b) i_req[o_idx]=0 (owner withdrew)
  - (c) counter==MAX_HOLD-1 (timeout)
- On release, at that edge: o_en=0, ptr=(o_idx+1) mod 4 (2-bit wrap, 3->0), counter=0, go to IDLE. o_timeout=1 for that single cycle only if (c) holds and neither (a) nor (b) holds.
- Simultaneous release causes: (a) or (b) wins over (c); no timeout pulse.
- Resulting grant length: a grant never exceeds MAX_HOLD cycles of o_en=1.
- Minimum gap: o_en is low for at least one cycle between consecutive grants, including re-grant of the same channel. The decoder therefore sees i_en=0 for one cycle between owners.
- Requests from non-owners during GRANT are ignored. They are not latched; they are re-evaluated in IDLE.
- o_idx changes only when entering GRANT or on reset.
- Fairness: with all four requesting continuously, every channel is granted once per four grants.
- i_done in IDLE has no effect.

Test Plan:
1. Assert i_rst for 2 cycles with i_req=4'b0000, then release reset, 5 cycles idle -> o_en=0, o_idx=0, o_timeout=0 throughout.
2. i_req=4'b1111 held; pulse i_done on the 3rd cycle of each grant -> o_idx sequence 0,1,2,3,0. Each grant has o_en high 3 cycles with a 1-cycle gap. Decoder output is 0001,0010,0100,1000,0001 during grants and 0000 in gaps.
3. i_req=4'b1010 after reset, i_done after 1 cycle each -> grants 1,3,1,3. Channels 0 and 2 are never granted.
4. i_req=4'b0001 held, i_done=0, MAX_HOLD=8 -> o_en high exactly 8 cycles, o_timeout=1 on the release cycle only, o_en low 1 cycle, then channel 0 re-granted.
5. Channel 2 granted, then i_req[2] dropped while i_done=1 and counter==MAX_HOLD-1 -> o_en=0 after that edge, o_timeout=0, next grant scans from channel 3.
6. i_rst asserted during a channel-3 grant -> o_en=0, o_idx=0 after the edge. With i_req=4'b1111 afterwards, the first grant is channel 0 (ptr reset).

Source files
------------

// File: rtl/dec2_rr_arb.sv
// Four-channel round-robin arbiter feeding a 2-to-4 decoder: drives an encoded
// grant index plus enable, holding each grant until done, withdrawal or timeout.
module dec2_rr_arb #(
  parameter int MAX_HOLD = 8
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [3:0] i_req,
  input  logic       i_done,
  output logic [1:0] o_idx,
  output logic       o_en,
  output logic       o_timeout,
  output logic       dbg_state
);

  localparam int CW = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(MAX_HOLD - 1);

  // Handshake: a grant is valid in every cycle o_en is high; o_idx is stable
  // for the whole grant, and o_en drops for at least one cycle between grants.
  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    idx_q, idx_d;
  logic [1:0]    ptr_q, ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          to_q, to_d;

  logic [1:0]    pick;
  logic          pick_vld;
  logic [1:0]    cand;
  logic          rel_done, rel_wd, rel_to;

  // Scan requesters starting at the round-robin pointer, wrapping 3 -> 0.
  always_comb begin
    pick     = 2'd0;
    pick_vld = 1'b0;
    cand     = 2'd0;
    for (int i = 0; i < 4; i++) begin
      cand = ptr_q + 2'(i);
      if (!pick_vld && i_req[cand]) begin
        pick     = cand;
        pick_vld = 1'b1;
      end
    end
  end

  assign rel_done = i_done;
  assign rel_wd   = ~i_req[idx_q];
  assign rel_to   = (cnt_q == CNT_LAST);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    to_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          idx_d   = pick;
          cnt_d   = '0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (rel_done || rel_wd || rel_to) begin
          ptr_d   = idx_q + 2'd1;
          cnt_d   = '0;
          state_d = IDLE;
          // Timeout is only flagged when nothing else released the grant.
          to_d    = rel_to && !rel_done && !rel_wd;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      idx_q   <= 2'd0;
      ptr_q   <= 2'd0;
      cnt_q   <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      to_q    <= to_d;
    end
  end

  assign o_idx     = idx_q;
  assign o_en      = (state_q == GRANT);
  assign o_timeout = to_q;
  assign dbg_state = state_q;

endmodule
